// File: rtl/enable_sequencer.sv
// enable_sequencer: runtime-programmable multi-channel enable sequencer.
// After a start trigger, each channel's enable is asserted in order. Each
// channel waits its own delay, counted from the previous channel's assertion.
// A channel is either held high (level), asserted for a fixed number of
// cycles (pulse), or skipped without changing its output.

module enable_sequencer #(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 16,
  parameter int DEFAULT_DELAY = 10
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic                                    cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                        cfg_delay,
  input  logic [1:0]                              cfg_mode,
  input  logic [CNT_W-1:0]                        cfg_len,
  output logic [NUM_CH-1:0]                       en_out,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    cfg_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CH_W  = $clog2(NUM_CH) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DELAY_RESET = CNT_W'(DEFAULT_DELAY);
  localparam logic [CH_W-1:0]  CH_ONE      = CH_W'(1);
  localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);
  localparam logic [IDX_W:0]   NUM_CH_EXT  = (IDX_W + 1)'(NUM_CH);

  localparam logic [1:0] MODE_LEVEL = 2'd0;
  localparam logic [1:0] MODE_PULSE = 2'd1;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  ch;
  logic [CNT_W-1:0] delay_r   [NUM_CH];
  logic [1:0]       mode_r    [NUM_CH];
  logic [CNT_W-1:0] len_r     [NUM_CH];
  logic [CNT_W-1:0] pulse_cnt [NUM_CH];

  logic [IDX_W-1:0] ch_idx;
  logic             cfg_ok;
  logic [CNT_W-1:0] pulse_load;

  // Decode the current channel, the legality of a config write and the pulse
  // length to load (a programmed length of zero still yields one cycle).
  always_comb begin
    ch_idx     = ch[IDX_W-1:0];
    cfg_ok     = cfg_we && (state == IDLE) && ({1'b0, cfg_ch} < NUM_CH_EXT) &&
                 (cfg_mode != MODE_RSVD);
    pulse_load = (len_r[ch_idx] == '0) ? CNT_ONE : len_r[ch_idx];
  end

  // Sequencer state machine, config registers and per-channel pulse timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ch      <= '0;
      en_out  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        delay_r[k]   <= DELAY_RESET;
        mode_r[k]    <= MODE_LEVEL;
        len_r[k]     <= CNT_ONE;
        pulse_cnt[k] <= '0;
      end
    end else begin
      done    <= 1'b0;
      cfg_err <= cfg_we && !cfg_ok;

      if (cfg_ok) begin
        delay_r[cfg_ch] <= cfg_delay;
        mode_r[cfg_ch]  <= cfg_mode;
        len_r[cfg_ch]   <= cfg_len;
      end

      if (abort) begin
        state  <= IDLE;
        cnt    <= '0;
        ch     <= '0;
        en_out <= '0;
        busy   <= 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
          pulse_cnt[k] <= '0;
        end
      end else begin
        if (state != IDLE) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (pulse_cnt[k] != '0) begin
              pulse_cnt[k] <= pulse_cnt[k] - CNT_ONE;
              if (pulse_cnt[k] == CNT_ONE) begin
                en_out[k] <= 1'b0;
              end
            end
          end
        end

        case (state)
          IDLE: begin
            if (start) begin
              state <= WAIT;
              ch    <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          WAIT: begin
            if (cnt == delay_r[ch_idx]) begin
              case (mode_r[ch_idx])
                MODE_LEVEL: en_out[ch_idx] <= 1'b1;
                MODE_PULSE: begin
                  en_out[ch_idx]    <= 1'b1;
                  pulse_cnt[ch_idx] <= pulse_load;
                end
                default: ;
              endcase
              cnt <= '0;
              ch  <= ch + CH_ONE;
              if (ch == LAST_CH) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= HOLD;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          HOLD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
